// File: rtl/alu_cmd_pkg.sv
// Shared types and widths for the ALU command issuer.
package alu_cmd_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned OP_W   = 3;

   // Opcode encoding seen by the external ALU.
   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } opcode_e;

   // Issue sequencer states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   // One response FIFO entry.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              carry;
   } rsp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
module resp_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign do_pop = pop && !empty;
   // Head reads as zero when empty so stale data never leaks out.
   assign rdata  = empty ? '0 : mem[rptr_q];

   // Storage write; no reset needed since reads are gated by empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= ptr_inc(wptr_q);
         end
         if (do_pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         unique case ({push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential front end for a 4-bit combinational ALU with accumulator and
// buffered response path.
module alu_cmd_issuer
   import alu_cmd_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_use_acc,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_carry,
   output logic [DATA_W-1:0] acc
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_e           state_q;
   state_e           state_d;
   logic             accept;
   logic             push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   rsp_t             wdata;
   rsp_t             rdata;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake and push strobe.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Space is reserved at accept time, so the later push cannot overflow.
            cmd_ready = (fifo_count < CNT_W'(DEPTH));
            if (cmd_valid && cmd_ready) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            push    = !fifo_full;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ALU operand registers and accumulator; operands hold between commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         acc    <= '0;
      end else begin
         if (accept) begin
            alu_a  <= cmd_use_acc ? acc : cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
         end
         if (push) begin
            acc <= alu_result;
         end
      end
   end

   assign wdata.result = alu_result;
   assign wdata.carry  = alu_carry;

   resp_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wdata),
      .pop   (rsp_ready),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rsp_valid  = !fifo_empty;
   assign rsp_result = rdata.result;
   assign rsp_carry  = rdata.carry;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: bench-side ALU, transaction-level
// model compared every cycle, plus directed literal expectations.
module tb_alu_cmd_issuer;

   localparam int unsigned DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic       cmd_use_acc = 1'b0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic [3:0] alu_result;
   logic       alu_carry;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic [3:0] acc;

   int errors = 0;
   int checks = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_use_acc (cmd_use_acc),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_carry   (alu_carry),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_carry   (rsp_carry),
      .acc         (acc)
   );

   // Reference 4-bit ALU: returns {carry, result}.
   function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
      logic [4:0] s;
      case (op)
         3'd0: s = {1'b0, a} + {1'b0, b};
         3'd1: s = {(a < b), 4'(a - b)};
         3'd2: s = {1'b0, a & b};
         3'd3: s = {1'b0, a | b};
         3'd4: s = {1'b0, a ^ b};
         3'd5: s = {1'b0, ~a};
         3'd6: s = {1'b0, 4'(a << 1)};
         default: s = {1'b0, a >> 1};
      endcase
      return s;
   endfunction

   // The ALU sits outside the DUT.
   always_comb {alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_op);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: a response queue, one in-flight slot, accumulator.
   logic [4:0] mq[$];
   logic       m_busy = 1'b0;
   logic [4:0] m_pend = '0;
   logic [3:0] m_acc = '0;
   logic [3:0] m_a = '0;
   logic [3:0] m_b = '0;
   logic [2:0] m_op = '0;
   logic       prev_valid = 1'b0;

   always @(posedge clk) begin
      int  pre_size;
      logic m_rdy;
      logic [3:0] a;
      #1;
      if (!rst_n) begin
         mq.delete();
         m_busy     = 1'b0;
         m_acc      = '0;
         m_a        = '0;
         m_b        = '0;
         m_op       = '0;
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && rsp_ready) hs_cnt++;
         pre_size = mq.size();
         m_rdy    = !m_busy && (pre_size < DEPTH);
         if (pre_size > 0 && rsp_ready) void'(mq.pop_front());
         if (m_busy) begin
            mq.push_back(m_pend);
            m_acc  = m_pend[3:0];
            m_busy = 1'b0;
         end else if (cmd_valid && m_rdy) begin
            a      = cmd_use_acc ? m_acc : cmd_a;
            m_a    = a;
            m_b    = cmd_b;
            m_op   = cmd_op;
            m_pend = alu_fn(a, cmd_b, cmd_op);
            m_busy = 1'b1;
         end
         prev_valid = rsp_valid;
      end
      chk("cmd_ready", int'(cmd_ready), int'(!m_busy && (mq.size() < DEPTH)));
      chk("rsp_valid", int'(rsp_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("rsp_result", int'(rsp_result), int'(mq[0][3:0]));
         chk("rsp_carry", int'(rsp_carry), int'(mq[0][4]));
      end else begin
         chk("rsp_result_idle", int'(rsp_result), 0);
      end
      chk("acc", int'(acc), int'(m_acc));
      chk("alu_a", int'(alu_a), int'(m_a));
      chk("alu_b", int'(alu_b), int'(m_b));
      chk("alu_op", int'(alu_op), int'(m_op));
   end

   // Present a command and hold it until accepted; returns on the negedge after acceptance.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ua);
      int n;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_use_acc = ua;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("send_accept_timeout", 0, 1);
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_use_acc = 1'b0;
   endtask

   // Wait for a response, check it against literals, then consume it.
   task automatic take_rsp(input string nm, input int r, input int c);
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_valid"}, int'(rsp_valid), 1);
      chk({nm, "_result"}, int'(rsp_result), r);
      chk({nm, "_carry"}, int'(rsp_carry), c);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_result", int'(rsp_result), 0);
      chk("rst_rsp_carry", int'(rsp_carry), 0);
      chk("rst_acc", int'(acc), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD 5+3: operands one cycle after accept, response the cycle after.
      send(3'd0, 4'd5, 4'd3, 1'b0);
      chk("t1_alu_a", int'(alu_a), 5);
      chk("t1_alu_b", int'(alu_b), 3);
      chk("t1_alu_op", int'(alu_op), 0);
      chk("t1_cmd_ready_low", int'(cmd_ready), 0);
      chk("t1_rsp_not_yet", int'(rsp_valid), 0);
      @(negedge clk);
      chk("t1_rsp_valid", int'(rsp_valid), 1);
      chk("t1_acc", int'(acc), 8);
      take_rsp("t1", 8, 0);

      // Carry and borrow corners.
      send(3'd0, 4'd9, 4'd8, 1'b0);
      take_rsp("add_wrap", 1, 1);
      send(3'd1, 4'd3, 4'd5, 1'b0);
      take_rsp("sub_borrow", 14, 1);
      send(3'd1, 4'd5, 4'd3, 1'b0);
      take_rsp("sub_plain", 2, 0);

      // Accumulator chain; cmd_a must be ignored when use_acc is set.
      send(3'd0, 4'd2, 4'd2, 1'b0);
      send(3'd0, 4'd13, 4'd7, 1'b1);
      take_rsp("chain1", 4, 0);
      take_rsp("chain2", 11, 0);
      chk("chain_acc", int'(acc), 11);
      send(3'd4, 4'd0, 4'd15, 1'b1);
      take_rsp("chain_xor", 4, 0);

      // Backpressure: FIFO fills, third command stalls until a pop.
      send(3'd0, 4'd1, 4'd1, 1'b0);
      send(3'd0, 4'd3, 4'd4, 1'b0);
      @(negedge clk);
      chk("bp_ready_low", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      cmd_a     = 4'd5;
      cmd_b     = 4'd10;
      repeat (3) begin
         @(negedge clk);
         chk("bp_stall", int'(cmd_ready), 0);
      end
      take_rsp("bp1", 2, 0);
      send(3'd3, 4'd5, 4'd10, 1'b0);
      take_rsp("bp2", 7, 0);
      take_rsp("bp3", 15, 0);
      @(negedge clk);
      chk("bp_drained", int'(rsp_valid), 0);

      // Continuous stream with the consumer always ready.
      hs_cnt    = 0;
      rsp_ready = 1'b1;
      send(3'd0, 4'd15, 4'd1, 1'b0);
      send(3'd5, 4'd6, 4'd0, 1'b0);
      send(3'd6, 4'd9, 4'd0, 1'b0);
      send(3'd7, 4'd9, 4'd0, 1'b0);
      send(3'd2, 4'd12, 4'd10, 1'b0);
      send(3'd1, 4'd0, 4'd1, 1'b0);
      repeat (4) @(negedge clk);
      chk("stream_handshakes", hs_cnt, 6);
      chk("stream_acc", int'(acc), 15);
      rsp_ready = 1'b0;

      // Reset while the AND 12&10 is in flight.
      send(3'd2, 4'd12, 4'd10, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_acc", int'(acc), 0);
      chk("abort_rsp_valid", int'(rsp_valid), 0);
      chk("abort_cmd_ready", int'(cmd_ready), 1);
      repeat (2) @(negedge clk);
      chk("abort_no_late_rsp", int'(rsp_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential front end for the 4-bit combinational ALU. Accepts operation commands over a valid/ready interface, registers operands and opcode into the ALU, captures the ALU result and carry one cycle later, and returns them over a buffered valid/ready response interface. A 4-bit accumulator is updated on every completion and can replace operand A, so dependent operation chains need no external feedback.

## Interface
- DEPTH, 2: response FIFO entries. Legal values are 1 to 8.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_use_acc  in  1  when 1, operand A is the accumulator value at accept time and cmd_a is ignored.
- alu_a, alu_b  out  4 each  registered operands driven to the ALU.
- alu_op  out  3  registered opcode driven to the ALU.
- alu_result  in  4  ALU result.
- alu_carry  in  1  ALU carry. For ADD it is the carry out. For SUB it is the borrow, 1 when A < B. For all other opcodes it is 0.
- rsp_valid  out  1  response FIFO is not empty.
- rsp_ready  in  1  consumer takes the head entry on a cycle where rsp_valid and rsp_ready are both high.
- rsp_result  out  4  result of the head entry.
- rsp_carry  out  1  carry of the head entry.
- acc  out  4  current accumulator value.

## Operation
- FSM states: IDLE and ISSUE.
- IDLE:
  - cmd_ready = (count < DEPTH), evaluated combinationally.
  - On accept: alu_a <= (cmd_use_acc ? acc : cmd_a), alu_b <= cmd_b, alu_op <= cmd_op, then go to ISSUE.
- ISSUE:
  - cmd_ready = 0.
  - Push {alu_result, alu_carry} into the FIFO.
  - acc <= alu_result.
  - Go to IDLE unconditionally.
- The push never overflows: space is checked at accept time and only one command is in flight.
- The FIFO pops on a response handshake. Push and pop in the same cycle leave the count unchanged and keep ordering.
- The consumer may hold rsp_ready low indefinitely. cmd_ready then stays low once count = DEPTH. No entry is dropped or overwritten.
- alu_a, alu_b and alu_op hold their values in IDLE; they are not cleared.
- Reset:
  - state = IDLE.
  - FIFO emptied: count = 0, read and write pointers = 0.
  - acc, alu_a, alu_b and alu_op all 0.
  - Outputs during and after reset: rsp_valid = 0, rsp_result = 0, rsp_carry = 0, cmd_ready = 1.
- Reset asserted while in ISSUE aborts the command. No response is produced and acc is not updated.
- Results wrap modulo 16. The only indication of wrap is the carry/borrow bit.

## Timing
- Accept at edge N. alu_* outputs are valid after edge N. The capture happens at edge N+1. rsp_valid is high after edge N+1 if the FIFO was empty.
- Latency: 2 cycles from command accept to response visible.
- Throughput: one command per 2 cycles. cmd_ready is low in the cycle after every accept.
- Back-to-back dependent chains with cmd_use_acc = 1 see the accumulator already updated at the next accept.
- The ALU path is combinational; only a single-cycle budget from the alu_* registers through the ALU to the FIFO and acc is required.

## Structure
- Package alu_cmd_pkg holds:
  - opcode_e enum with values 0 to 7 as listed under cmd_op;
  - state_e enum {IDLE, ISSUE};
  - localparams DATA_W = 4 and OP_W = 3.
- Sub-module resp_fifo: a synchronous FIFO.
  - Entry width DATA_W + 1.
  - Depth DEPTH.
  - Same clk and rst_n.
  - Outputs full, empty and count.
  - First-word-fall-through head.
- The ALU itself is instantiated by the bench or top level, not inside this block.

## Test plan
- Reset then ADD a=5, b=3 -> alu_a=5, alu_b=3, alu_op=0 after 1 cycle; after 2 cycles rsp_result=8, rsp_carry=0, acc=8.
- ADD 9+8 -> rsp_result=1, rsp_carry=1. SUB 3-5 -> result 14, carry 1. SUB 5-3 -> result 2, carry 0.
- Chain: ADD 2+2, then ADD with cmd_use_acc=1 and b=7 -> responses 4 then 11, acc=11; then XOR with cmd_use_acc=1 and b=15 -> response 4.
- Backpressure with DEPTH=2 and rsp_ready held 0: issue 3 commands -> cmd_ready drops after the second response is captured; releasing rsp_ready delivers all 3 responses in order with no loss.
- Simultaneous push and pop: rsp_ready held 1 during a continuous command stream -> count never exceeds 1, every response appears exactly once.
- Reset pulse during ISSUE of AND 12&10 -> no response, acc=0, rsp_valid=0, cmd_ready=1 after reset is released.
